// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM state encodings plus reset-PC and flush-NOP defaults.
package fetch_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_FILL = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_W_DEF      = 32;
    localparam int unsigned INSTR_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [15:0] CNT_MAX       = 16'hFFFF;

endpackage

// File: rtl/fetch_pipe_ctrl_pc_reg.sv
// Program counter with sequential increment and ID-stage redirect; a stalled IF/ID
// (ifid_write_i=0) freezes the PC and defers any redirect until the stall clears.
module fetch_pipe_ctrl_pc_reg #(
    parameter int unsigned       PC_W     = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            ifid_write_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o
);

    logic [PC_W-1:0] pc_q, pc_d;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + PC_W'(4);

    always_comb begin
        pc_d = pc_q;
        if (ifid_write_i) begin
            if (branch_taken_i) begin
                pc_d = branch_target_i;
            end else if (pc_write_i) begin
                pc_d = pc_plus4_o;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side stall/flush consumer: owns PC (via pc_reg) and the IF/ID register.
// Optional stall/flush statistics counters are built only when STALL_STATS_EN is defined.
//   state | meaning
//   FILL  | first edge after reset release, IF/ID not yet holding a real instruction
//   RUN   | IF/ID loading every edge
//   HOLD  | IF/ID frozen by the hazard unit
module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter int unsigned          PC_W      = PC_W_DEF,
    parameter int unsigned          INSTR_W   = INSTR_W_DEF,
    parameter logic [PC_W-1:0]      RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pc_write_i,
    input  logic               ifid_write_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]    imem_addr_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc4_o,
    output logic               ifid_valid_o,
    output logic [15:0]        stall_cnt_o,
    output logic [15:0]        flush_cnt_o
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_plus4;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc4_q, pc4_d;
    logic               valid_q, valid_d;

    fetch_pipe_ctrl_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_write_i      (pc_write_i),
        .ifid_write_i    (ifid_write_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .pc_o            (imem_addr_o),
        .pc_plus4_o      (pc_plus4)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_FILL: state_d = ifid_write_i ? FETCH_RUN : FETCH_HOLD;
            FETCH_RUN:  if (!ifid_write_i) state_d = FETCH_HOLD;
            FETCH_HOLD: if (ifid_write_i)  state_d = FETCH_RUN;
            default:    state_d = FETCH_FILL;
        endcase
    end

    // A flush keeps the old pc4 so decode still sees a coherent (if invalid) tag.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (ifid_write_i) begin
            if (branch_taken_i) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_rdata_i;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FETCH_FILL;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign ifid_instr_o = instr_q;
    assign ifid_pc4_o   = pc4_q;
    assign ifid_valid_o = valid_q;

`ifdef STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ifid_write_i && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (ifid_write_i && branch_taken_i && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Scoreboard bench for fetch_pipe_ctrl: driver updates a reference model and queues the
// expected post-edge outputs; an independent monitor pops and compares after each edge/reset.
module tb_fetch_pipe_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] stall;
        logic [15:0] flush;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        ifid_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;
    exp_t sb_q[$];

    // Reference model state, expressed as the architectural pipeline contents.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_stalls, m_flushes;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    assign imem_rdata = imem_f(imem_addr);

    fetch_pipe_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .ifid_write_i    (ifid_write),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .imem_rdata_i    (imem_rdata),
        .imem_addr_o     (imem_addr),
        .ifid_instr_o    (ifid_instr),
        .ifid_pc4_o      (ifid_pc4),
        .ifid_valid_o    (ifid_valid),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    function automatic exp_t snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.valid = m_valid;
`ifdef STALL_STATS_EN
        e.stall = (m_stalls  > 65535) ? 16'hFFFF : 16'(m_stalls);
        e.flush = (m_flushes > 65535) ? 16'hFFFF : 16'(m_flushes);
`else
        e.stall = 16'h0;
        e.flush = 16'h0;
`endif
        e.tag   = step_no;
        return e;
    endfunction

    task automatic model_reset();
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Called at a falling edge: apply inputs, predict the next rising edge, wait one cycle.
    task automatic drive(input logic pw, input logic iw, input logic bt, input logic [31:0] tgt);
        pc_write      = pw;
        ifid_write    = iw;
        branch_taken  = bt;
        branch_target = tgt;
        step_no++;
        if (!iw) begin
            m_stalls++;
        end else if (bt) begin
            m_flushes++;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_pc    = tgt;
        end else begin
            m_instr = imem_f(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (pw) m_pc = m_pc + 32'd4;
        end
        sb_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("imem_addr",  e.tag, imem_addr,           e.pc);
                chk("ifid_instr", e.tag, ifid_instr,          e.instr);
                chk("ifid_pc4",   e.tag, ifid_pc4,            e.pc4);
                chk("ifid_valid", e.tag, {31'h0, ifid_valid}, {31'h0, e.valid});
                chk("stall_cnt",  e.tag, {16'h0, stall_cnt},  {16'h0, e.stall});
                chk("flush_cnt",  e.tag, {16'h0, flush_cnt},  {16'h0, e.flush});
            end
        end
    end

    initial begin : driver
        logic        pw, iw, bt;
        logic [31:0] tgt;

        #2;
        rst = 1'b1;
        model_reset();
        sb_q.push_back(snapshot());
        @(negedge clk);
        rst = 1'b0;

        // Fill and run: A @0, B @4, then stall three cycles at PC=0x8.
        drive(1, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        // Flush to 0x40, deferred redirect while stalled, then a redirect to the wrap point.
        drive(1, 1, 1, 32'h0000_0040);
        drive(1, 1, 0, 32'h0);
        drive(0, 0, 1, 32'h0000_0080);
        drive(1, 0, 1, 32'h0000_0080);
        drive(1, 1, 1, 32'h0000_0080);
        drive(1, 1, 1, 32'hFFFF_FFFC);
        drive(1, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        drive(0, 1, 0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            iw  = ($urandom_range(0, 3) != 0);
            pw  = iw ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 7) == 0);
            bt  = ($urandom_range(0, 5) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            drive(pw, iw, bt, tgt);
        end

        // Reset in the middle of a stall with a redirect pending.
        drive(1, 1, 0, 32'h0);
        drive(0, 0, 1, 32'h0000_0100);
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        branch_taken = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        step_no++;
        sb_q.push_back(snapshot());
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
